// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer: walks the channels set in a mask, driving the
// {enable,x,y} select of a 3-to-8 decoder. Optional macro: SCAN_SEQ_PASS_COUNT_EN.
module scan_select_sequencer #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned PASS_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [7:0]        chan_mask,
  output logic              x,
  output logic              y,
  output logic              enable,
  output logic              sel_valid,
  output logic              busy,
  output logic              done,
  output logic              start_err,
  output logic [PASS_W-1:0] pass_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEK,
    S_DWELL,
    S_DONE
  } state_t;

  localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  mask_q, mask_d;
  logic        cont_q, cont_d;
  logic [15:0] cnt_q, cnt_d;
  logic        eop;

  logic        sel_valid_q, sel_valid_d;
  logic [2:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_err_q, start_err_d;

  // Next-state, pointer and dwell-counter logic; eop marks end of a pass
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mask_d      = mask_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    eop         = 1'b0;
    start_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (|chan_mask) begin
            mask_d  = chan_mask;
            cont_d  = continuous;
            ptr_d   = 3'd0;
            state_d = S_SEEK;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      S_SEEK: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (mask_q[ptr_q]) begin
          cnt_d   = DWELL_LOAD;
          state_d = S_DWELL;
        end else if (ptr_q != 3'd7) begin
          ptr_d = ptr_q + 3'd1;
        end else begin
          eop = 1'b1;
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'd0) begin
          if (ptr_q != 3'd7) begin
            ptr_d   = ptr_q + 3'd1;
            state_d = S_SEEK;
          end else begin
            eop = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (eop) begin
      ptr_d   = 3'd0;
      state_d = cont_q ? S_SEEK : S_DONE;
    end
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    sel_valid_d = (state_d == S_DWELL);
    sel_d       = sel_valid_d ? ptr_d : 3'd0;
    busy_d      = (state_d == S_SEEK) || (state_d == S_DWELL);
    done_d      = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      mask_q      <= 8'd0;
      cont_q      <= 1'b0;
      cnt_q       <= 16'd0;
      sel_valid_q <= 1'b0;
      sel_q       <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
      sel_valid_q <= sel_valid_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
    end
  end

`ifdef SCAN_SEQ_PASS_COUNT_EN
  logic [PASS_W-1:0] pass_count_q, pass_count_d;

  // Completed-pass counter, wraps naturally; only reset clears it
  always_comb begin
    pass_count_d = pass_count_q + (eop ? PASS_W'(1) : PASS_W'(0));
  end

  // Pass counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_count_q <= '0;
    end else begin
      pass_count_q <= pass_count_d;
    end
  end

  assign pass_count = pass_count_q;
`else
  assign pass_count = '0;
`endif

  assign enable    = sel_q[2];
  assign x         = sel_q[1];
  assign y         = sel_q[0];
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign start_err = start_err_q;

endmodule
